// File: rtl/reg_port_arbiter.sv
// Two-port round-robin sequencer in front of a single register file: IDLE -> ISSUE -> RESP.
// Optional REG_ARB_R0_ZERO_EN makes register 0 read as zero and suppresses writes to it.
module reg_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rf_read_en,
  output logic                  rf_write_en,
  output logic [ADDR_W-1:0]     rf_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  input  logic [DATA_W-1:0]     rf_read_data,
  output logic                  busy
);

`ifdef REG_ARB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic                winner;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_we;

  always_comb begin
    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    winner      = req_valid[1] & (~req_valid[0] | ~last_grant_q);
    win_addr    = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    win_we      = req_we[winner];
    req_ready   = '0;
    state_d     = state_q;
    last_grant_d = last_grant_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[winner] = 1'b1;
          grant_d      = winner;
          last_grant_d = winner;
          we_d         = win_we;
          addr_d       = win_addr;
          wdata_d      = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          rd_en_d      = ~win_we;
          wr_en_d      = win_we & ~(R0_ZERO && (win_addr == '0));
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        rsp_valid_d[grant_q] = 1'b1;
        state_d              = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if (state_q == RESP && !we_q && !(R0_ZERO && (addr_q == '0)))
      rsp_rdata = rf_read_data;
  end

  // A reset asserted while in RESP must suppress the pulse already on the flop.
  assign rsp_valid     = rsp_valid_q & {2{rst}};
  assign rf_read_en    = rd_en_q;
  assign rf_write_en   = wr_en_q;
  assign rf_addr       = addr_q;
  assign rf_write_data = wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a behavioural 16x32 register file (registered read).
// Expectations for register 0 follow REG_ARB_R0_ZERO_EN when the bench is built with it.
module tb_reg_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, rf_write_data, rf_read_data;
  logic        rf_read_en, rf_write_en, busy;
  logic [3:0]  rf_addr;
  logic [31:0] mem [16];
  int          tests = 0;
  int          fails = 0;

`ifdef REG_ARB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rf_read_en(rf_read_en),
    .rf_write_en(rf_write_en), .rf_addr(rf_addr), .rf_write_data(rf_write_data),
    .rf_read_data(rf_read_data), .busy(busy)
  );

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rf_read_data = '0;
  end

  always @(posedge clk) begin
    if (rf_write_en === 1'b1) mem[rf_addr] <= rf_write_data;
    if (rf_read_en === 1'b1) rf_read_data <= mem[rf_addr];
  end

  always @(negedge clk) begin
    tests++;
    assert ((rf_read_en & rf_write_en) !== 1'b1)
      else begin fails++; $error("FAIL collision observed rd=%b wr=%b expected not both 1", rf_read_en, rf_write_en); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin fails++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation starting in IDLE; leaves the DUT back in IDLE.
  task automatic run_op(input string tag, input logic [1:0] valid, input logic [1:0] we,
                        input int exp_port, input logic exp_we, input logic [3:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic exp_wr_pulse,
                        input logic [31:0] exp_rdata, input logic hold);
    logic [1:0] onehot;
    onehot = (exp_port == 1) ? 2'b10 : 2'b01;
    req_valid = valid;
    req_we    = we;
    #1;
    chk({tag, "_ready"}, req_ready, onehot);
    tick();
    if (!hold) req_valid = 2'b00;
    #1;
    chk({tag, "_rd_en"}, rf_read_en, !exp_we);
    chk({tag, "_wr_en"}, rf_write_en, exp_wr_pulse);
    chk({tag, "_addr"}, rf_addr, exp_addr);
    if (exp_we) chk({tag, "_wdata"}, rf_write_data, exp_wdata);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_noready_issue"}, req_ready, 2'b00);
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, onehot);
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_en_off"}, {rf_read_en, rf_write_en}, 2'b00);
    chk({tag, "_noready_resp"}, req_ready, 2'b00);
    $display("[TB] op %s port=%0d we=%0b addr=%0d rdata=%h", tag, exp_port, exp_we, exp_addr, rsp_rdata);
    tick();
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("rst_outputs", {rsp_valid, rf_read_en, rf_write_en, rf_addr, rf_write_data, rsp_rdata, busy},
        '0);
    chk("rst_ready", req_ready, 2'b00);
    rst = 1'b1;
    tick();

    // First tie after reset goes to port 0.
    req_addr = {4'd6, 4'd5};
    run_op("tie_first", 2'b11, 2'b00, 0, 1'b0, 4'd5, 32'h0, 1'b0, 32'h0, 1'b0);

    // Write then read back through port 0.
    req_addr = {4'd0, 4'd3}; req_wdata = {32'h0, 32'hDEADBEEF};
    run_op("p0_wr3", 2'b01, 2'b01, 0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    run_op("p0_rd3", 2'b01, 2'b00, 0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Port 1 read so that port 0 owns the next tie.
    req_addr = {4'd3, 4'd3};
    run_op("p1_rd3", 2'b10, 2'b00, 1, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Both ports continuously valid: grants alternate 0,1,0,1,0,1.
    req_addr = {4'd9, 4'd3}; req_wdata = {32'hCAFEF00D, 32'h0};
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        run_op("rr_p0", 2'b11, 2'b10, 0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
      else
        run_op("rr_p1", 2'b11, 2'b10, 1, 1'b1, 4'd9, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    end
    req_addr = {4'd0, 4'd9};
    run_op("p0_rd9", 2'b01, 2'b00, 0, 1'b0, 4'd9, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Reset during RESP of a port-1 read of address 15.
    req_addr = {4'd15, 4'd0};
    req_valid = 2'b10; req_we = 2'b00;
    #1;
    chk("abort_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("abort_rd_en", rf_read_en, 1'b1);
    chk("abort_addr", rf_addr, 4'd15);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_no_rsp", rsp_valid, 2'b00);
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_after", rsp_valid, 2'b00);
    chk("abort_rf_clr", {rf_read_en, rf_write_en, rf_addr}, '0);
    rst = 1'b1;
    tick();
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_idle_rsp", rsp_valid, 2'b00);
    $display("[TB] op abort port=1 addr=15 busy=%0b rsp_valid=%b", busy, rsp_valid);
    req_addr = {4'd15, 4'd3};
    run_op("tie_after_rst", 2'b11, 2'b00, 0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Register 0 behaviour.
    req_addr = {4'd0, 4'd0}; req_wdata = {32'h0, 32'h12345678};
    run_op("r0_wr", 2'b01, 2'b01, 0, 1'b1, 4'd0, 32'h12345678, !R0Z, 32'h0, 1'b0);
    run_op("r0_rd", 2'b01, 2'b00, 0, 1'b0, 4'd0, 32'h0, 1'b0, R0Z ? 32'h0 : 32'h12345678, 1'b0);

    // Port 0 raises valid while busy and drops it before ever seeing ready.
    req_addr = {4'd7, 4'd2};
    req_valid = 2'b10; req_we = 2'b00;
    #1;
    chk("drop_p1_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    #1;
    chk("drop_ready_issue", req_ready, 2'b00);
    tick();
    chk("drop_ready_resp", req_ready, 2'b00);
    chk("drop_p1_rsp", rsp_valid, 2'b10);
    req_valid = 2'b00;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("drop_no_en", {rf_read_en, rf_write_en}, 2'b00);
      chk("drop_busy", busy, 1'b0);
      tick();
    end
    $display("[TB] op drop port=0 busy=%0b rd=%0b wr=%0b", busy, rf_read_en, rf_write_en);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
